// File: rtl/mac_ifmaps_multirow_fifo.sv
// Multi-row ifmaps FIFO between the ifmaps loader and the MAC PE rows.
// Each entry holds NUM_ROWS row words. The read port is registered and pulses out_valid for one cycle per read.
module mac_ifmaps_multirow_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_ROWS   = 5,
   parameter int DEPTH      = 4,
   parameter int AF_MARGIN  = 1,
   parameter int AE_MARGIN  = 1,
   localparam int W  = NUM_ROWS * DATA_WIDTH,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [W-1:0]  ifmaps_in,
   input  logic          ifmaps_input_valid,
   input  logic          fifo_read,
   output logic [W-1:0]  ifmaps_out,
   output logic          ifmaps_out_valid,
   output logic [CW-1:0] fifo_count,
   output logic          fifo_full,
   output logic          fifo_empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          overflow_err,
   output logic          underflow_err
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          read_en, write_en;

   always_comb begin
      fifo_full    = (fifo_count == CW'(DEPTH));
      fifo_empty   = (fifo_count == '0);
      almost_full  = (fifo_count >= CW'(DEPTH - AF_MARGIN));
      almost_empty = (fifo_count <= CW'(AE_MARGIN));
      // A pop frees the slot the same cycle, so a full FIFO still takes a write alongside a read.
      read_en      = fifo_read & ~fifo_empty & ~flush;
      write_en     = ifmaps_input_valid & (~fifo_full | fifo_read) & ~flush;
   end

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // The entry storage has no reset, so it is written in its own block.
   always_ff @(posedge clk) begin
      if (write_en) mem[wr_ptr] <= ifmaps_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         fifo_count       <= '0;
         ifmaps_out       <= '0;
         ifmaps_out_valid <= 1'b0;
         overflow_err     <= 1'b0;
         underflow_err    <= 1'b0;
      end else if (flush) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         fifo_count       <= '0;
         ifmaps_out_valid <= 1'b0;
         overflow_err     <= 1'b0;
         underflow_err    <= 1'b0;
      end else begin
         ifmaps_out_valid <= read_en;
         if (write_en) wr_ptr <= ptr_next(wr_ptr);
         if (read_en) begin
            rd_ptr     <= ptr_next(rd_ptr);
            ifmaps_out <= mem[rd_ptr];
         end
         case ({write_en, read_en})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (ifmaps_input_valid & ~write_en) overflow_err  <= 1'b1;
         if (fifo_read & fifo_empty)         underflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mac_ifmaps_multirow_fifo.sv
// Directed bench for mac_ifmaps_multirow_fifo: DEPTH=4 main instance plus a DEPTH=3 instance for pointer wrap.
// Written words are queued in a scoreboard and popped when out_valid is observed.
module tb_mac_ifmaps_multirow_fifo;

   localparam int W = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // DEPTH=4 instance
   logic          rst, flush, in_valid, rd;
   logic [W-1:0]  din, dout;
   logic          out_valid, full, empty, afull, aempty, ovf, udf;
   logic [2:0]    count;

   mac_ifmaps_multirow_fifo #(.DATA_WIDTH(8), .NUM_ROWS(5), .DEPTH(4), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .ifmaps_in(din), .ifmaps_input_valid(in_valid),
      .fifo_read(rd), .ifmaps_out(dout), .ifmaps_out_valid(out_valid), .fifo_count(count),
      .fifo_full(full), .fifo_empty(empty), .almost_full(afull), .almost_empty(aempty),
      .overflow_err(ovf), .underflow_err(udf));

   // DEPTH=3 instance
   logic          b_flush, b_valid, b_rd;
   logic [W-1:0]  b_din, b_dout;
   logic          b_out_valid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
   logic [1:0]    b_count;

   mac_ifmaps_multirow_fifo #(.DATA_WIDTH(8), .NUM_ROWS(5), .DEPTH(3), .AF_MARGIN(1), .AE_MARGIN(1)) dut_b (
      .clk(clk), .rst(rst), .flush(b_flush), .ifmaps_in(b_din), .ifmaps_input_valid(b_valid),
      .fifo_read(b_rd), .ifmaps_out(b_dout), .ifmaps_out_valid(b_out_valid), .fifo_count(b_count),
      .fifo_full(b_full), .fifo_empty(b_empty), .almost_full(b_afull), .almost_empty(b_aempty),
      .overflow_err(b_ovf), .underflow_err(b_udf));

   // Bench model for instance A
   logic [W-1:0] sb[$];
   logic [W-1:0] rdq[$];
   int           m_count;
   logic         m_ovf, m_udf, m_rd;
   logic [W-1:0] m_out;
   // Bench model for instance B
   logic [W-1:0] sb_b[$];
   logic [W-1:0] rdq_b[$];
   int           mb_count;
   logic         mb_rd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] pat(input logic [7:0] b);
      logic [W-1:0] w;
      for (int r = 0; r < 5; r++) w[r*8 +: 8] = b + 8'(r);
      return w;
   endfunction

   task automatic check_a(input string tag);
      logic [W-1:0] e;
      chk({tag, ".valid"}, 64'(out_valid), 64'(m_rd));
      if (out_valid) begin
         if (rdq.size() == 0) chk({tag, ".spurious"}, 64'(1), 64'(0));
         else begin
            e = rdq.pop_front();
            chk({tag, ".data"}, 64'(dout), 64'(e));
         end
      end
      chk({tag, ".out_hold"}, 64'(dout), 64'(m_out));
      chk({tag, ".count"}, 64'(count), 64'(m_count));
      chk({tag, ".full"}, 64'(full), 64'(m_count == 4));
      chk({tag, ".empty"}, 64'(empty), 64'(m_count == 0));
      chk({tag, ".afull"}, 64'(afull), 64'(m_count >= 3));
      chk({tag, ".aempty"}, 64'(aempty), 64'(m_count <= 1));
      chk({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
      chk({tag, ".udf"}, 64'(udf), 64'(m_udf));
   endtask

   task automatic step(input string tag, input logic v, input logic r, input logic [W-1:0] d, input logic fl);
      logic ex_rd, ex_wr;
      in_valid = v; rd = r; din = d; flush = fl;
      ex_rd = r & (m_count != 0) & ~fl;
      ex_wr = v & ((m_count != 4) | r) & ~fl;
      if (fl) begin
         sb.delete(); rdq.delete();
         m_count = 0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         if (v & ~ex_wr) m_ovf = 1'b1;
         if (r & (m_count == 0)) m_udf = 1'b1;
         if (ex_rd) begin
            m_out = sb.pop_front();
            rdq.push_back(m_out);
         end
         if (ex_wr) sb.push_back(d);
         m_count = m_count + int'(ex_wr) - int'(ex_rd);
      end
      m_rd = ex_rd;
      @(posedge clk); #1;
      in_valid = 1'b0; rd = 1'b0; flush = 1'b0;
      check_a(tag);
   endtask

   task automatic step_b(input string tag, input logic v, input logic r, input logic [W-1:0] d);
      logic ex_rd, ex_wr;
      logic [W-1:0] e;
      b_valid = v; b_rd = r; b_din = d;
      ex_rd = r & (mb_count != 0);
      ex_wr = v & ((mb_count != 3) | r);
      if (ex_rd) rdq_b.push_back(sb_b.pop_front());
      if (ex_wr) sb_b.push_back(d);
      mb_count = mb_count + int'(ex_wr) - int'(ex_rd);
      mb_rd = ex_rd;
      @(posedge clk); #1;
      b_valid = 1'b0; b_rd = 1'b0;
      chk({tag, ".valid"}, 64'(b_out_valid), 64'(mb_rd));
      if (b_out_valid) begin
         if (rdq_b.size() == 0) chk({tag, ".spurious"}, 64'(1), 64'(0));
         else begin
            e = rdq_b.pop_front();
            chk({tag, ".data"}, 64'(b_dout), 64'(e));
         end
      end
      chk({tag, ".count"}, 64'(b_count), 64'(mb_count));
      chk({tag, ".ovf"}, 64'(b_ovf), 64'(0));
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; rd = 1'b0; din = '0;
      b_flush = 1'b0; b_valid = 1'b0; b_rd = 1'b0; b_din = '0;
      m_count = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rd = 1'b0; m_out = '0;
      mb_count = 0; mb_rd = 1'b0;
      #12 rst = 1'b0;
      @(posedge clk); #1;
      check_a("reset");
      chk("reset.b_empty", 64'(b_empty), 64'(1));

      // T1 fill / drain
      step("t1.w0", 1, 0, pat(8'h11), 0);
      step("t1.w1", 1, 0, pat(8'h22), 0);
      step("t1.w2", 1, 0, pat(8'h33), 0);
      step("t1.w3", 1, 0, pat(8'h44), 0);
      for (int i = 0; i < 4; i++) step("t1.rd", 0, 1, '0, 0);
      step("t1.idle", 0, 0, '0, 0);

      // T2 wrap with interleaved write/read
      for (int i = 0; i < 10; i++) step("t2.wr", 1, (i > 0), pat(8'(8'h50 + 8'(i * 8))), 0);
      step("t2.tail", 0, 1, '0, 0);
      step("t2.after", 0, 0, '0, 0);

      // Empty + read + write: read rejected, write accepted
      step("edge.empty_rw", 1, 1, pat(8'hA0), 0);
      step("edge.drain", 0, 1, '0, 0);

      // T3 full + simultaneous read/write
      for (int i = 0; i < 4; i++) step("t3.fill", 1, 0, pat(8'(8'hB0 + 8'(i))), 0);
      step("t3.full_rw", 1, 1, pat(8'hC0), 0);
      step("t3.full_rw2", 1, 1, pat(8'hC8), 0);

      // T4 errors: overflow, drain, underflow, flush
      step("t4.ovf", 1, 0, pat(8'hEE), 0);
      for (int i = 0; i < 4; i++) step("t4.drain", 0, 1, '0, 0);
      step("t4.udf", 0, 1, '0, 0);
      step("t4.flush", 0, 0, '0, 1);

      // T6 flush mid-stream with valid and read asserted
      step("t6.w0", 1, 0, pat(8'h61), 0);
      step("t6.w1", 1, 0, pat(8'h62), 0);
      step("t6.flush", 1, 1, pat(8'h63), 1);
      step("t6.post", 0, 1, '0, 0);
      step("t6.w2", 1, 0, pat(8'h64), 0);
      step("t6.rd", 0, 1, '0, 0);

      // Async reset between edges while out_valid is high
      step("t6.w3", 1, 0, pat(8'h71), 0);
      in_valid = 1'b1; rd = 1'b1; din = pat(8'h72);
      @(posedge clk); #2;
      chk("t6.pre_rst_valid", 64'(out_valid), 64'(1));
      rst = 1'b1;
      #1;
      chk("t6.rst_count", 64'(count), 64'(0));
      chk("t6.rst_valid", 64'(out_valid), 64'(0));
      chk("t6.rst_out", 64'(dout), 64'(0));
      chk("t6.rst_empty", 64'(empty), 64'(1));
      in_valid = 1'b0; rd = 1'b0;
      #1 rst = 1'b0;
      sb.delete(); rdq.delete();
      m_count = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rd = 1'b0; m_out = '0;
      @(posedge clk); #1;
      check_a("t6.after_rst");

      // T2 on DEPTH=3 instance
      for (int i = 0; i < 3; i++) step_b("t2b.fill", 1, 0, pat(8'(8'h80 + 8'(i))));
      chk("t2b.full", 64'(b_full), 64'(1));
      for (int i = 0; i < 7; i++) step_b("t2b.rw", 1, 1, pat(8'(8'h90 + 8'(i * 8))));
      for (int i = 0; i < 3; i++) step_b("t2b.drain", 0, 1, '0);
      step_b("t2b.idle", 0, 0, '0);
      chk("t2b.empty", 64'(b_empty), 64'(1));
      chk("t2b.sb_left", 64'(sb_b.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
